// File: rtl/sseg_pkg.sv
// sseg_pkg: shared seven-segment font constants and bit positions
package sseg_pkg;
  localparam logic [7:0] SEG_0 = 8'hC0;
  localparam logic [7:0] SEG_1 = 8'hF9;
  localparam logic [7:0] SEG_2 = 8'hA4;
  localparam logic [7:0] SEG_3 = 8'hB0;
  localparam logic [7:0] SEG_4 = 8'h99;
  localparam logic [7:0] SEG_5 = 8'h92;
  localparam logic [7:0] SEG_6 = 8'h82;
  localparam logic [7:0] SEG_7 = 8'hF8;
  localparam logic [7:0] SEG_8 = 8'h80;
  localparam logic [7:0] SEG_9 = 8'h90;
  localparam logic [7:0] SEG_A = 8'h88;
  localparam logic [7:0] SEG_B = 8'h83;
  localparam logic [7:0] SEG_C = 8'hC6;
  localparam logic [7:0] SEG_D = 8'hA1;
  localparam logic [7:0] SEG_E = 8'h86;
  localparam logic [7:0] SEG_F = 8'h8E;
  localparam logic [7:0] SEGS_BLANK = 8'hFF;
  localparam int DP_BIT = 7;
endpackage

// File: rtl/hex_to_sseg.sv
// hex_to_sseg: active-low hex font with decimal point overlay
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       dp,
  output logic [7:0] seg
);
  logic [7:0] pat;
  // glyph lookup, then clear the DP cathode when the point is lit
  always_comb begin
    case (nib)
      4'h0: pat = SEG_0;
      4'h1: pat = SEG_1;
      4'h2: pat = SEG_2;
      4'h3: pat = SEG_3;
      4'h4: pat = SEG_4;
      4'h5: pat = SEG_5;
      4'h6: pat = SEG_6;
      4'h7: pat = SEG_7;
      4'h8: pat = SEG_8;
      4'h9: pat = SEG_9;
      4'hA: pat = SEG_A;
      4'hB: pat = SEG_B;
      4'hC: pat = SEG_C;
      4'hD: pat = SEG_D;
      4'hE: pat = SEG_E;
      default: pat = SEG_F;
    endcase
    seg = pat;
    seg[DP_BIT] = pat[DP_BIT] & ~dp;
  end
endmodule

// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl: 4-digit multiplexed seven-segment scanner with frame-synchronous updates
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] DATA_IN,
  input  logic [3:0]  DP_IN,
  input  logic        LD,
  input  logic        BLANK_LZ,
  input  logic        EN,
  output logic [1:0]  SEL,
  output logic [7:0]  SEGS,
  output logic        FRAME,
  output logic        UPD_PEND
);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    sel_q, sel_d;
  logic [15:0]   pend_dat_q, pend_dat_d, disp_dat_q, disp_dat_d;
  logic [3:0]    pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic          upd_q, upd_d, frame_q, frame_d;
  logic          tick, wrap;
  logic [3:0]    nib;
  logic          dp_sel, hi_zero, blank;
  logic [7:0]    pat;
  // scan timing and frame-boundary hand-off from pending to display registers
  always_comb begin
    tick       = cnt_q == CNT_MAX;
    wrap       = tick && sel_q == 2'd3;
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    sel_d      = sel_q + {1'b0, tick};
    pend_dat_d = (LD && !wrap) ? DATA_IN : pend_dat_q;
    pend_dp_d  = (LD && !wrap) ? DP_IN : pend_dp_q;
    disp_dat_d = !wrap ? disp_dat_q : LD ? DATA_IN : upd_q ? pend_dat_q : disp_dat_q;
    disp_dp_d  = !wrap ? disp_dp_q : LD ? DP_IN : upd_q ? pend_dp_q : disp_dp_q;
    upd_d      = wrap ? 1'b0 : (LD | upd_q);
    frame_d    = wrap;
  end
  // state registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cnt_q      <= '0;
      sel_q      <= '0;
      pend_dat_q <= '0;
      pend_dp_q  <= '0;
      disp_dat_q <= '0;
      disp_dp_q  <= '0;
      upd_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      pend_dat_q <= pend_dat_d;
      pend_dp_q  <= pend_dp_d;
      disp_dat_q <= disp_dat_d;
      disp_dp_q  <= disp_dp_d;
      upd_q      <= upd_d;
      frame_q    <= frame_d;
    end
  end
  // a digit is a leading zero when it and every nibble above it are zero
  always_comb begin
    nib     = disp_dat_q[{sel_q, 2'b00} +: 4];
    dp_sel  = disp_dp_q[sel_q];
    hi_zero = (disp_dat_q >> {sel_q, 2'b00}) == 16'h0;
    blank   = BLANK_LZ && sel_q != 2'd0 && !dp_sel && hi_zero;
    SEGS    = (!EN || blank) ? SEGS_BLANK : pat;
  end
  hex_to_sseg u_font (
    .nib (nib),
    .dp  (dp_sel),
    .seg (pat)
  );
  assign SEL      = sel_q;
  assign FRAME    = frame_q;
  assign UPD_PEND = upd_q;
endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// tb_sseg_scan_ctrl: randomized bench against a time-indexed behavioural model
module tb_sseg_scan_ctrl;
  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [15:0] DATA_IN = '0;
  logic [3:0]  DP_IN = '0;
  logic        LD = 1'b0;
  logic        BLANK_LZ = 1'b0;
  logic        EN = 1'b1;
  logic [1:0]  SEL;
  logic [7:0]  SEGS;
  logic        FRAME;
  logic        UPD_PEND;
  int tests = 0;
  int fails = 0;
  localparam logic [7:0] FNT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          t;
  logic [15:0] m_dat, m_pend;
  logic [3:0]  m_dp, m_pp;
  logic        m_upd, m_frame;

  sseg_scan_ctrl #(.CLK_DIV(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .DATA_IN(DATA_IN), .DP_IN(DP_IN), .LD(LD),
    .BLANK_LZ(BLANK_LZ), .EN(EN), .SEL(SEL), .SEGS(SEGS), .FRAME(FRAME), .UPD_PEND(UPD_PEND)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", nm, t, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_segs();
    int s = (t / 4) % 4;
    logic [3:0] n = m_dat[s*4 +: 4];
    logic p = m_dp[s];
    logic lz = 1'b1;
    logic [7:0] f;
    for (int k = s; k < 4; k++) if (m_dat[k*4 +: 4] != 4'h0) lz = 1'b0;
    if (!EN || (BLANK_LZ && s != 0 && !p && lz)) return 8'hFF;
    f = FNT[n];
    if (p) f[7] = 1'b0;
    return f;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    if (!RST_N) begin
      t = 0; m_dat = '0; m_pend = '0; m_dp = '0; m_pp = '0; m_upd = 1'b0; m_frame = 1'b0;
    end else begin
      m_frame = (t % 16) == 15;
      if (m_frame) begin
        if (LD) begin m_dat = DATA_IN; m_dp = DP_IN; end
        else if (m_upd) begin m_dat = m_pend; m_dp = m_pp; end
        m_upd = 1'b0;
      end else if (LD) begin
        m_pend = DATA_IN; m_pp = DP_IN; m_upd = 1'b1;
      end
      t++;
    end
    @(negedge CLK);
    chk("sel", 32'(SEL), 32'((t / 4) % 4));
    chk("segs", 32'(SEGS), 32'(exp_segs()));
    chk("frame", 32'(FRAME), 32'(m_frame));
    chk("upd_pend", 32'(UPD_PEND), 32'(m_upd));
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] p);
    LD = 1'b1; DATA_IN = d; DP_IN = p;
    cyc();
    LD = 1'b0;
  endtask

  task automatic expect_digits(input logic [7:0] l0, input logic [7:0] l1,
                               input logic [7:0] l2, input logic [7:0] l3);
    logic [7:0] l [4];
    int n = 0;
    l[0] = l0; l[1] = l1; l[2] = l2; l[3] = l3;
    while (!FRAME && n < 40) begin cyc(); n++; end
    if (!FRAME) chk("frame_wait", 32'(FRAME), 32'd1);
    else for (int k = 0; k < 4; k++) begin
      chk("lit_sel", 32'(SEL), 32'(k));
      chk("lit_digit", 32'(SEGS), 32'(l[k]));
      repeat (4) cyc();
    end
  endtask

  initial begin
    int nf;
    logic [15:0] r;
    RST_N = 1'b0;
    cyc(); cyc();
    RST_N = 1'b1;
    chk("rst_segs", 32'(SEGS), 32'hC0);
    chk("rst_upd", 32'(UPD_PEND), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("sel_seq", 32'(SEL), 32'(i / 4));
      cyc();
    end
    load(16'h12AF, 4'h0);
    chk("ld_upd", 32'(UPD_PEND), 32'd1);
    expect_digits(8'h8E, 8'h88, 8'hA4, 8'hF9);
    BLANK_LZ = 1'b1;
    load(16'h0040, 4'b0100);
    expect_digits(8'hC0, 8'h99, 8'h40, 8'hFF);
    load(16'h0040, 4'b0000);
    expect_digits(8'hC0, 8'h99, 8'hFF, 8'hFF);
    BLANK_LZ = 1'b0;
    while (t % 16 != 5) cyc();
    load(16'h1111, 4'h0);
    while (t % 16 != 15) cyc();
    load(16'h2222, 4'h0);
    chk("wrap_ld_upd", 32'(UPD_PEND), 32'd0);
    chk("wrap_ld_frame", 32'(FRAME), 32'd1);
    expect_digits(8'hA4, 8'hA4, 8'hA4, 8'hA4);
    load(16'h1234, 4'h0);
    chk("pre_rst_upd", 32'(UPD_PEND), 32'd1);
    while ((t / 4) % 4 != 2) cyc();
    RST_N = 1'b0;
    cyc();
    RST_N = 1'b1;
    chk("mid_rst_sel", 32'(SEL), 32'd0);
    chk("mid_rst_upd", 32'(UPD_PEND), 32'd0);
    chk("mid_rst_frame", 32'(FRAME), 32'd0);
    chk("mid_rst_segs", 32'(SEGS), 32'hC0);
    EN = 1'b0;
    nf = 0;
    for (int i = 0; i < 48; i++) begin
      cyc();
      if (FRAME) nf++;
    end
    chk("en0_frames", 32'(nf), 32'd3);
    chk("en0_segs", 32'(SEGS), 32'hFF);
    EN = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = 16'($urandom);
      DATA_IN = r >> (4 * $urandom_range(0, 4));
      DP_IN = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      LD = $urandom_range(0, 7) == 0;
      EN = $urandom_range(0, 15) != 0;
      if (i % 50 == 0) BLANK_LZ = 1'($urandom);
      RST_N = $urandom_range(0, 299) != 0;
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
